// File: rtl/nasti_lite_pkg.sv
// Shared definitions for the NASTI-lite IO write slave.
//  - B response codes
//  - write FSM state encoding
package nasti_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/nasti_lite_fifo.sv
// Small synchronous FIFO used to buffer the lite AW and W channels.
// Ports:
//  clk, rstn          clock, async active-low reset (empties the FIFO)
//  push, din          write side; ignored while full
//  pop, dout          read side; dout is the head entry, valid while !empty
//  full, empty        status flags
module nasti_lite_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "nasti_lite_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [PW:0]      wptr, rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign dout  = mem[rptr[PW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + PTR_ONE;
            if (pop && !empty)
                rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/nasti_lite_io_writer.sv
// NASTI-lite write slave driving a simple IO register port.
// AW and W are buffered independently, paired in order, and each pair becomes
// one word write on io_*; a single lite B (AW id/user) is returned per pair.
// Ports:
//  clk, rstn                       clock, async active-low reset
//  lite_aw_*                       write address channel (prot/qos/region ignored)
//  lite_w_*                        write data channel (user ignored)
//  lite_b_*                        write response channel
//  io_we/io_addr/io_wdata/io_wstrb IO write request, held until io_ready
//  io_ready, io_err                IO accept strobe and error flag
module nasti_lite_io_writer
    import nasti_lite_pkg::*;
#(
    parameter int                    ID_WIDTH      = 1,
    parameter int                    ADDR_WIDTH    = 8,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    USER_WIDTH    = 1,
    parameter int                    AW_DEPTH      = 2,
    parameter int                    W_DEPTH       = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                    IO_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [ID_WIDTH-1:0]       lite_aw_id,
    input  logic [ADDR_WIDTH-1:0]     lite_aw_addr,
    input  logic [2:0]                lite_aw_prot,
    input  logic [3:0]                lite_aw_qos,
    input  logic [3:0]                lite_aw_region,
    input  logic [USER_WIDTH-1:0]     lite_aw_user,
    input  logic                      lite_aw_valid,
    output logic                      lite_aw_ready,
    input  logic [DATA_WIDTH-1:0]     lite_w_data,
    input  logic [DATA_WIDTH/8-1:0]   lite_w_strb,
    input  logic [USER_WIDTH-1:0]     lite_w_user,
    input  logic                      lite_w_valid,
    output logic                      lite_w_ready,
    output logic [ID_WIDTH-1:0]       lite_b_id,
    output logic [1:0]                lite_b_resp,
    output logic [USER_WIDTH-1:0]     lite_b_user,
    output logic                      lite_b_valid,
    input  logic                      lite_b_ready,
    output logic                      io_we,
    output logic [IO_ADDR_WIDTH-1:0]  io_addr,
    output logic [DATA_WIDTH-1:0]     io_wdata,
    output logic [DATA_WIDTH/8-1:0]   io_wstrb,
    input  logic                      io_ready,
    input  logic                      io_err
);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $fatal(1, "nasti_lite_io_writer: DATA_WIDTH must be 32 or 64");
    end
    if (USER_WIDTH < 1) begin : g_bad_uw
        $fatal(1, "nasti_lite_io_writer: USER_WIDTH must be > 0");
    end

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(BYTES);
    localparam int AWE_W    = ID_WIDTH + ADDR_WIDTH + USER_WIDTH;
    localparam int WE_W     = DATA_WIDTH + BYTES;

    // Window bounds carry one extra bit so a window ending at the top of the
    // address space does not wrap to zero.
    localparam logic [ADDR_WIDTH:0] BASE_X  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] LIMIT_X =
        BASE_X + (ADDR_WIDTH+1)'((2**IO_ADDR_WIDTH) * BYTES);

    logic                  unused_inputs;
    assign unused_inputs = ^{lite_aw_prot, lite_aw_qos, lite_aw_region, lite_w_user};

    // ---------------- channel buffers ----------------
    logic [AWE_W-1:0]      aw_head;
    logic [WE_W-1:0]       w_head;
    logic                  aw_full, aw_empty, w_full, w_empty;
    logic                  pop;

    nasti_lite_fifo #(.DEPTH(AW_DEPTH), .WIDTH(AWE_W)) u_aw_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (lite_aw_valid),
        .din   ({lite_aw_id, lite_aw_addr, lite_aw_user}),
        .pop   (pop),
        .dout  (aw_head),
        .full  (aw_full),
        .empty (aw_empty)
    );

    nasti_lite_fifo #(.DEPTH(W_DEPTH), .WIDTH(WE_W)) u_w_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (lite_w_valid),
        .din   ({lite_w_data, lite_w_strb}),
        .pop   (pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign lite_aw_ready = !aw_full;
    assign lite_w_ready  = !w_full;

    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [USER_WIDTH-1:0] aw_user;
    assign {aw_id, aw_addr, aw_user} = aw_head;

    // ---------------- decode ----------------
    logic [ADDR_WIDTH:0]   addr_x, offs;
    logic                  in_range, go_write, have_pair;

    assign addr_x    = {1'b0, aw_addr};
    assign in_range  = (addr_x >= BASE_X) && (addr_x < LIMIT_X);
    assign offs      = addr_x - BASE_X;
    assign go_write  = in_range && (w_head[BYTES-1:0] != '0);
    assign have_pair = !aw_empty && !w_empty;

    // IO request comes straight from the FIFO heads, which only move on pop.
    assign io_addr   = IO_ADDR_WIDTH'(offs >> OFF_BITS);
    assign io_wdata  = w_head[WE_W-1:BYTES];
    assign io_wstrb  = w_head[BYTES-1:0];

    // ---------------- FSM ----------------
    state_e     state, state_nxt;
    logic       load_b;
    logic [1:0] resp_nxt;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_b    = 1'b0;
        resp_nxt  = RESP_OKAY;
        case (state)
            ST_IDLE: begin
                if (have_pair) begin
                    if (go_write) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        // Decode error or empty strobe: answer without touching IO.
                        pop       = 1'b1;
                        load_b    = 1'b1;
                        resp_nxt  = in_range ? RESP_OKAY : RESP_DECERR;
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_WRITE: begin
                if (io_ready) begin
                    pop       = 1'b1;
                    load_b    = 1'b1;
                    resp_nxt  = io_err ? RESP_SLVERR : RESP_OKAY;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (lite_b_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            lite_b_id   <= '0;
            lite_b_resp <= RESP_OKAY;
            lite_b_user <= '0;
        end else begin
            state <= state_nxt;
            if (load_b) begin
                lite_b_id   <= aw_id;
                lite_b_resp <= resp_nxt;
                lite_b_user <= aw_user;
            end
        end
    end

    assign io_we        = (state == ST_WRITE);
    assign lite_b_valid = (state == ST_RESP);

endmodule
